// File: rtl/race_pkg.sv
// Shared constants and types for the race game controller.
package race_pkg;

  // Screen encoding; doubles as the controller FSM state.
  typedef enum logic [1:0] {
    SCR_MENU = 2'd0,
    SCR_RACE = 2'd1,
    SCR_END  = 2'd2
  } screen_e;

  localparam int unsigned NUM_PLAYERS   = 4;
  localparam int unsigned PLAYER_BLUE   = 0;
  localparam int unsigned PLAYER_RED    = 1;
  localparam int unsigned PLAYER_GREEN  = 2;
  localparam int unsigned PLAYER_YELLOW = 3;

  // Bits needed to hold positions 0..max_pos inclusive.
  function automatic int unsigned pos_w(input int unsigned max_pos);
    return $clog2(max_pos + 1);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; pulses expired on the cycle it steps from 1 to 0.
module cycle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // Load has priority over counting; counting stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  // A reload in the final cycle restarts the delay instead of expiring.
  assign o_expired = !i_load && (r_count == W'(1));

endmodule

// File: rtl/race_game_ctrl.sv
// Race game controller: menu join, race position tracking, winner and end screen.
module race_game_ctrl
  import race_pkg::*;
#(
  parameter int unsigned MAX_POS              = 109,
  parameter int unsigned MENU_TIMER_CLK_COUNT = 10,
  parameter int unsigned END_TIMER_CLK_COUNT  = 20,
  localparam int unsigned POS_W               = pos_w(MAX_POS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PLAYERS-1:0]       btn_press,
  input  logic                         frame_ack,
  output logic [1:0]                   cur_screen,
  output logic [NUM_PLAYERS-1:0]       ready_to_play,
  output logic [NUM_PLAYERS*POS_W-1:0] pos,
  output logic [1:0]                   winner,
  output logic                         winner_valid,
  output logic                         update_frame
);

  localparam int unsigned MENU_W = $clog2(MENU_TIMER_CLK_COUNT + 1);
  localparam int unsigned END_W  = $clog2(END_TIMER_CLK_COUNT + 1);
  localparam logic [MENU_W-1:0] MENU_LOAD = MENU_W'(MENU_TIMER_CLK_COUNT);
  localparam logic [END_W-1:0]  END_LOAD  = END_W'(END_TIMER_CLK_COUNT);
  localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(MAX_POS - 1);

  screen_e                r_state;
  logic [NUM_PLAYERS-1:0] r_ready;
  logic [POS_W-1:0]       r_pos [NUM_PLAYERS];
  logic [1:0]             r_winner;
  logic                   r_winner_valid;
  logic                   r_update;

  logic [NUM_PLAYERS-1:0] w_new_ready;
  logic [NUM_PLAYERS-1:0] w_inc_mask;
  logic [NUM_PLAYERS-1:0] w_hit;
  logic [1:0]             w_win_idx;
  logic                   w_menu_load;
  logic                   w_end_load;
  logic                   w_menu_exp;
  logic                   w_end_exp;
  logic                   w_chg;

  // Per-player join/advance qualification and lowest-index winner pick.
  always_comb begin
    w_new_ready = '0;
    w_inc_mask  = '0;
    w_hit       = '0;
    w_win_idx   = '0;
    if (r_state == SCR_MENU) begin
      w_new_ready = btn_press & ~r_ready;
    end
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      if (r_state == SCR_RACE && !r_winner_valid && btn_press[k] &&
          r_ready[k] && r_pos[k] != POS_MAX) begin
        w_inc_mask[k] = 1'b1;
        w_hit[k]      = (r_pos[k] == POS_LAST);
      end
    end
    // Scan from the highest index down so the lowest hitting index wins.
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      if (w_hit[NUM_PLAYERS-1-k]) begin
        w_win_idx = 2'(NUM_PLAYERS - 1 - k);
      end
    end
  end

  assign w_menu_load = |w_new_ready;
  assign w_end_load  = (r_state == SCR_RACE) && r_winner_valid;

  cycle_timer #(.W(MENU_W)) u_menu_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_menu_load),
    .i_load_val (MENU_LOAD),
    .o_expired  (w_menu_exp)
  );

  cycle_timer #(.W(END_W)) u_end_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_end_load),
    .i_load_val (END_LOAD),
    .o_expired  (w_end_exp)
  );

  // Flags any cycle whose edge will change screen, ready flags or positions.
  always_comb begin
    w_chg = 1'b0;
    case (r_state)
      SCR_MENU: w_chg = w_menu_load || w_menu_exp;
      SCR_RACE: w_chg = (|w_inc_mask) || r_winner_valid;
      SCR_END:  w_chg = w_end_exp;
      default:  w_chg = 1'b1;
    endcase
  end

  // Game FSM with all visible outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= SCR_MENU;
      r_ready        <= '0;
      r_winner       <= '0;
      r_winner_valid <= 1'b0;
      r_update       <= 1'b0;
      for (int unsigned k = 0; k < NUM_PLAYERS; k++) r_pos[k] <= '0;
    end else begin
      r_update <= w_chg || (r_update && !frame_ack);
      case (r_state)
        SCR_MENU: begin
          r_ready <= r_ready | w_new_ready;
          if (w_menu_exp) begin
            r_state <= SCR_RACE;
            for (int unsigned k = 0; k < NUM_PLAYERS; k++) r_pos[k] <= '0;
          end
        end
        SCR_RACE: begin
          if (r_winner_valid) begin
            r_state <= SCR_END;
          end
          for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
            if (w_inc_mask[k]) r_pos[k] <= r_pos[k] + 1'b1;
          end
          if (|w_hit) begin
            r_winner       <= w_win_idx;
            r_winner_valid <= 1'b1;
          end
        end
        SCR_END: begin
          if (w_end_exp) begin
            r_state        <= SCR_MENU;
            r_ready        <= '0;
            r_winner       <= '0;
            r_winner_valid <= 1'b0;
            for (int unsigned k = 0; k < NUM_PLAYERS; k++) r_pos[k] <= '0;
          end
        end
        default: r_state <= SCR_MENU;
      endcase
    end
  end

  // Pack per-player positions, player 0 in the LSBs.
  always_comb begin
    pos = '0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      pos[k*POS_W +: POS_W] = r_pos[k];
    end
  end

  assign cur_screen    = r_state;
  assign ready_to_play = r_ready;
  assign winner        = r_winner;
  assign winner_valid  = r_winner_valid;
  assign update_frame  = r_update;

endmodule

// File: tb/tb_race_game_ctrl.sv
// Directed self-checking bench for race_game_ctrl at default parameters.
module tb_race_game_ctrl;

  localparam int unsigned PW = 7;

  logic          clk;
  logic          rst;
  logic [3:0]    btn_press;
  logic          frame_ack;
  logic [1:0]    cur_screen;
  logic [3:0]    ready_to_play;
  logic [4*PW-1:0] pos;
  logic [1:0]    winner;
  logic          winner_valid;
  logic          update_frame;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned glitches;

  race_game_ctrl #(
    .MAX_POS              (109),
    .MENU_TIMER_CLK_COUNT (10),
    .END_TIMER_CLK_COUNT  (20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_press     (btn_press),
    .frame_ack     (frame_ack),
    .cur_screen    (cur_screen),
    .ready_to_play (ready_to_play),
    .pos           (pos),
    .winner        (winner),
    .winner_valid  (winner_valid),
    .update_frame  (update_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned getp(input int unsigned i);
    logic [4*PW-1:0] v;
    v = pos;
    return int'(v[i*PW +: PW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m);
    btn_press = m;
    tick();
    btn_press = '0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_screen"}, cur_screen, 0);
    check({tag, "_ready"}, ready_to_play, 0);
    check({tag, "_pos"}, pos, 0);
    check({tag, "_winner"}, winner, 0);
    check({tag, "_wvalid"}, winner_valid, 0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    glitches  = 0;
    rst       = 1'b1;
    btn_press = '0;
    frame_ack = 1'b0;
    repeat (3) tick();
    check_cleared("rst");
    check("rst_upd", update_frame, 0);
    rst = 1'b0;

    // Idle menu for 100 cycles.
    repeat (100) tick();
    check("idle_screen", cur_screen, 0);
    check("idle_upd", update_frame, 0);
    check("idle_ready", ready_to_play, 0);

    // Blue joins, red joins 4 cycles later.
    press(4'b0001);
    check("join_blue", ready_to_play, 4'b0001);
    check("join_upd", update_frame, 1);
    repeat (3) tick();
    check("upd_held", update_frame, 1);
    press(4'b0011);
    check("join_red", ready_to_play, 4'b0011);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check("ack_clears", update_frame, 0);
    repeat (8) tick();
    check("menu_wait", cur_screen, 0);
    tick();
    check("race_entry", cur_screen, 1);
    check("race_pos0", pos, 0);
    check("race_upd", update_frame, 1);

    // Non-ready yellow ignored; simultaneous blue+red each advance.
    press(4'b1000);
    check("yellow_ign", getp(3), 0);
    press(4'b0011);
    check("sim_blue", getp(0), 1);
    check("sim_red", getp(1), 1);
    repeat (49) press(4'b0001);
    check("blue50", getp(0), 50);
    check("blue50_scr", cur_screen, 1);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check_cleared("arst");
    check("arst_upd", update_frame, 0);
    repeat (2) tick();
    rst = 1'b0;

    // Blue-only game, first press on the first edge after reset release.
    press(4'b0001);
    check("rel_press", ready_to_play, 4'b0001);
    repeat (9) tick();
    check("a_menu", cur_screen, 0);
    tick();
    check("a_race", cur_screen, 1);
    for (int i = 0; i < 108; i++) begin
      press(4'b0001);
      if (update_frame !== 1'b1) glitches++;
      if (i < 5) begin
        press(4'b0100);
        if (update_frame !== 1'b1) glitches++;
      end
    end
    check("a_blue108", getp(0), 108);
    check("a_green0", getp(2), 0);
    check("a_novalid", winner_valid, 0);
    press(4'b0001);
    check("a_blue109", getp(0), 109);
    check("a_winner", winner, 0);
    check("a_wvalid", winner_valid, 1);
    check("a_still_race", cur_screen, 1);
    press(4'b1111);
    check("a_end", cur_screen, 2);
    check("a_sat", getp(0), 109);
    for (int i = 0; i < 19; i++) begin
      press(4'b1111);
      if (update_frame !== 1'b1) glitches++;
    end
    check("a_end_hold", cur_screen, 2);
    check("a_end_pos", getp(0), 109);
    tick();
    check_cleared("a_menu2");
    check("no_glitch", glitches, 0);
    frame_ack = 1'b1;
    tick();
    check("a_ack", update_frame, 0);
    tick();
    frame_ack = 1'b0;
    check("a_stray_ack", update_frame, 0);

    // Red and yellow tie at the finish; red wins.
    press(4'b1010);
    check("c_ready", ready_to_play, 4'b1010);
    repeat (10) tick();
    check("c_race", cur_screen, 1);
    frame_ack = 1'b1;
    repeat (108) press(4'b1010);
    check("c_coalesce", update_frame, 1);
    check("c_red108", getp(1), 108);
    check("c_yel108", getp(3), 108);
    press(4'b1010);
    frame_ack = 1'b0;
    check("c_winner", winner, 1);
    check("c_wvalid", winner_valid, 1);
    check("c_yel109", getp(3), 109);
    check("c_blue0", getp(0), 0);
    tick();
    check("c_end", cur_screen, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
